// File: rtl/arith_result_fifo.sv
// arith_result_fifo
// First-word-fall-through result FIFO behind the arith unit.
// - Captures each valid result/status pair from the arith unit.
// - Keeps sticky status, an overflow flag and a saturating drop counter.
// - Serves the consumer over a valid/ready handshake.
// The arith unit cannot be stalled, so bursts are absorbed here and any
// loss is reported instead of back-pressured.
// Optional build macro: ARITH_RESULT_FIFO_AFULL_EN enables the registered
// o_almost_full flag; without it o_almost_full is tied low.
module arith_result_fifo #(
    parameter int BITS         = 32,
    parameter int DEPTH        = 8,
    parameter int CNT_W        = 16,
    parameter int AFULL_THRESH = 6
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_valid,
    input  logic [BITS-1:0]            i_result,
    input  logic [3:0]                 i_status,
    input  logic                       i_ready,
    input  logic                       i_clear_sticky,
    output logic                       o_valid,
    output logic [BITS-1:0]            o_result,
    output logic [3:0]                 o_status,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic [3:0]                 o_sticky_status,
    output logic                       o_overflow,
    output logic [CNT_W-1:0]           o_drop_cnt,
    output logic                       o_almost_full
);

    // Address bits plus one wrap bit so full and empty can be told apart.
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Reject illegal configurations at elaboration time.
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("arith_result_fifo: DEPTH must be a power of 2 and at least 2");
        end
        if (AFULL_THRESH < 0) begin : g_bad_thresh
            $error("arith_result_fifo: AFULL_THRESH must not be negative");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Storage and pointers
    // ------------------------------------------------------------------
    logic [BITS-1:0] result_mem [DEPTH];
    logic [3:0]      status_mem [DEPTH];

    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   wr_ptr_next;
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW-1:0]   rd_ptr_next;

    logic [AW-1:0]   wr_addr;
    logic [AW-1:0]   rd_addr;

    logic            empty;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;

    assign wr_addr = wr_ptr_reg[AW-1:0];
    assign rd_addr = rd_ptr_reg[AW-1:0];

    // Same address: equal wrap bits mean empty, differing wrap bits mean full.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_addr == rd_addr) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    // a push while the consumer is reading. i_ready is meaningless when empty.
    assign pop  = !empty && i_ready;
    assign push = i_valid && (!full || pop);
    assign drop = i_valid && full && !pop;

    // Pointer advance for the coming edge.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PW'(1);
        end
    end

    // Pointer registers; reset discards every stored entry at once.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // Storage write; contents are left unreset and masked while empty.
    always_ff @(posedge i_clk) begin
        if (push) begin
            result_mem[wr_addr] <= i_result;
            status_mem[wr_addr] <= i_status;
        end
    end

    // Head entry falls through as soon as the read pointer settles.
    assign o_valid  = !empty;
    assign o_result = empty ? '0 : result_mem[rd_addr];
    assign o_status = empty ? '0 : status_mem[rd_addr];
    assign o_count  = wr_ptr_reg - rd_ptr_reg;
    assign o_full   = full;

    // ------------------------------------------------------------------
    // Sticky status, overflow flag and drop counter
    // ------------------------------------------------------------------
    logic [3:0]       sticky_reg;
    logic [3:0]       sticky_next;
    logic             overflow_reg;
    logic             overflow_next;
    logic [CNT_W-1:0] drop_cnt_reg;
    logic [CNT_W-1:0] drop_cnt_base;
    logic [CNT_W-1:0] drop_cnt_next;

    // Per bit: a clear wipes history, but status pushed in the same cycle survives.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sticky
            assign sticky_next[gi] = (push & i_status[gi]) |
                                     (~i_clear_sticky & sticky_reg[gi]);
        end
    endgenerate

    // A drop coinciding with a clear is still recorded as the first drop.
    assign overflow_next = (overflow_reg & ~i_clear_sticky) | drop;

    // Drop counter: clear first, then count this cycle's drop, saturating.
    always_comb begin
        drop_cnt_base = i_clear_sticky ? '0 : drop_cnt_reg;
        drop_cnt_next = drop_cnt_base;
        if (drop && (drop_cnt_base != {CNT_W{1'b1}})) begin
            drop_cnt_next = drop_cnt_base + CNT_W'(1);
        end
    end

    // Status/loss reporting registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sticky_reg   <= '0;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            sticky_reg   <= sticky_next;
            overflow_reg <= overflow_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    assign o_sticky_status = sticky_reg;
    assign o_overflow      = overflow_reg;
    assign o_drop_cnt      = drop_cnt_reg;

    // ------------------------------------------------------------------
    // Almost-full flag
    // ------------------------------------------------------------------
`ifdef ARITH_RESULT_FIFO_AFULL_EN
    logic [PW-1:0] count_next;
    logic          almost_full_reg;

    assign count_next = wr_ptr_next - rd_ptr_next;

    // Registered so it changes on the same edge as o_count.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            almost_full_reg <= 1'b0;
        end else begin
            almost_full_reg <= (32'(count_next) >= AFULL_THRESH);
        end
    end

    assign o_almost_full = almost_full_reg;
`else
    assign o_almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_arith_result_fifo.sv
// Directed self-checking bench for arith_result_fifo (DEPTH 8, BITS 32).
module tb_arith_result_fifo;

    localparam int BITS  = 32;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
`ifdef ARITH_RESULT_FIFO_AFULL_EN
    localparam bit AF_EN = 1'b1;
`else
    localparam bit AF_EN = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              valid_in;
    logic [BITS-1:0]   result_in;
    logic [3:0]        status_in;
    logic              ready_in;
    logic              clear_in;
    logic              valid_out;
    logic [BITS-1:0]   result_out;
    logic [3:0]        status_out;
    logic [3:0]        count_out;
    logic              full_out;
    logic [3:0]        sticky_out;
    logic              overflow_out;
    logic [CNT_W-1:0]  drop_out;
    logic              afull_out;

    int checks   = 0;
    int failures = 0;

    arith_result_fifo #(
        .BITS(BITS), .DEPTH(DEPTH), .CNT_W(CNT_W), .AFULL_THRESH(6)
    ) dut (
        .i_clk(clk), .i_reset(rst_n), .i_valid(valid_in), .i_result(result_in),
        .i_status(status_in), .i_ready(ready_in), .i_clear_sticky(clear_in),
        .o_valid(valid_out), .o_result(result_out), .o_status(status_out),
        .o_count(count_out), .o_full(full_out), .o_sticky_status(sticky_out),
        .o_overflow(overflow_out), .o_drop_cnt(drop_out), .o_almost_full(afull_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_af(input int cnt);
        return AF_EN && (cnt >= 6);
    endfunction

    logic [BITS-1:0] drain_exp [8];

    initial begin
        rst_n = 1'b0; valid_in = 1'b1; result_in = 32'h123; status_in = 4'hF;
        ready_in = 1'b0; clear_in = 1'b0;

        // Reset held with write attempts: everything stays zero.
        repeat (3) tick();
        check("rst_valid", valid_out, 0);
        check("rst_result", result_out, 0);
        check("rst_status", status_out, 0);
        check("rst_count", count_out, 0);
        check("rst_full", full_out, 0);
        check("rst_sticky", sticky_out, 0);
        check("rst_ovf", overflow_out, 0);
        check("rst_drop", drop_out, 0);
        check("rst_afull", afull_out, 0);
        $display("txn reset_hold count=%0d valid=%0b", count_out, valid_out);

        valid_in = 1'b0;
        rst_n = 1'b1;
        repeat (5) tick();
        check("idle_count", count_out, 0);
        check("idle_valid", valid_out, 0);

        // Ordered fill with rotating one-hot status.
        for (int i = 1; i <= 8; i++) begin
            valid_in = 1'b1; result_in = BITS'(i); status_in = 4'(1 << ((i - 1) % 4));
            tick();
            $display("txn push result=%0d status=%0h count=%0d", i, status_in, count_out);
            check("fill_count", count_out, 64'(i));
            check("fill_head", result_out, 1);
            check("fill_afull", afull_out, 64'(exp_af(i)));
        end
        valid_in = 1'b0;
        check("fill_full", full_out, 1);
        check("fill_sticky", sticky_out, 4'hF);
        check("fill_head_status", status_out, 4'h1);

        // Overflow: three dropped writes while full and not reading.
        for (int j = 0; j < 3; j++) begin
            valid_in = 1'b1; result_in = BITS'(100 + j); status_in = 4'h0;
            tick();
            $display("txn drop result=%0d drop_cnt=%0d", 100 + j, drop_out);
        end
        valid_in = 1'b0;
        check("ovf_flag", overflow_out, 1);
        check("ovf_drop", drop_out, 3);
        check("ovf_head", result_out, 1);
        check("ovf_count", count_out, 8);

        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        $display("txn clear_sticky");
        check("clr_ovf", overflow_out, 0);
        check("clr_drop", drop_out, 0);
        check("clr_sticky", sticky_out, 0);
        check("clr_count", count_out, 8);
        check("clr_head", result_out, 1);

        // Push and pop together while full.
        valid_in = 1'b1; result_in = 32'hA5A5A5A5; status_in = 4'h3; ready_in = 1'b1;
        tick();
        valid_in = 1'b0;
        $display("txn push_pop_full result=a5a5a5a5 count=%0d", count_out);
        check("pp_count", count_out, 8);
        check("pp_drop", drop_out, 0);
        check("pp_full", full_out, 1);

        // Drain: 2..8 then the late entry.
        for (int k = 0; k < 7; k++) drain_exp[k] = BITS'(k + 2);
        drain_exp[7] = 32'hA5A5A5A5;
        for (int k = 0; k < 8; k++) begin
            check("drain_valid", valid_out, 1);
            check("drain_result", result_out, 64'(drain_exp[k]));
            if (k == 7) check("drain_late_status", status_out, 4'h3);
            $display("txn pop result=%0h", result_out);
            tick();
        end
        ready_in = 1'b0;
        check("empty_valid", valid_out, 0);
        check("empty_result", result_out, 0);
        check("empty_status", status_out, 0);
        check("empty_count", count_out, 0);

        // Clear versus push.
        check("pre_sticky", sticky_out, 4'h3);
        valid_in = 1'b1; result_in = 32'h55; status_in = 4'hD; clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        check("clrpush_d", sticky_out, 4'hD);
        result_in = 32'h66; status_in = 4'h2; clear_in = 1'b1;
        tick();
        clear_in = 1'b0; valid_in = 1'b0;
        $display("txn clear_with_push status=2 sticky=%0h", sticky_out);
        check("clrpush_2", sticky_out, 4'h2);

        // Idle inputs with valid low must not touch sticky state.
        status_in = 4'hF; result_in = 32'hDEAD;
        tick();
        check("novalid_sticky", sticky_out, 4'h2);
        check("novalid_count", count_out, 2);

        ready_in = 1'b1;
        check("q_head0", result_out, 32'h55);
        check("q_stat0", status_out, 4'hD);
        tick();
        check("q_head1", result_out, 32'h66);
        check("q_stat1", status_out, 4'h2);
        tick();
        ready_in = 1'b0;
        check("q_empty", valid_out, 0);

        // Almost-full threshold crossing.
        for (int i = 1; i <= 6; i++) begin
            valid_in = 1'b1; result_in = BITS'(200 + i); status_in = 4'h0;
            tick();
            $display("txn push result=%0d count=%0d afull=%0b", 200 + i, count_out, afull_out);
            check("af_fill", afull_out, 64'(exp_af(i)));
        end
        valid_in = 1'b0; ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        check("af_pop_count", count_out, 5);
        check("af_pop", afull_out, 0);

        // Refill to full, then drops with a clear in the same cycle as the last.
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1; result_in = BITS'(300 + i);
            tick();
        end
        check("refill_full", full_out, 1);
        tick();
        tick();
        check("pre_clr_drop", drop_out, 2);
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0; valid_in = 1'b0;
        $display("txn drop_with_clear drop_cnt=%0d ovf=%0b", drop_out, overflow_out);
        check("dropclr_ovf", overflow_out, 1);
        check("dropclr_cnt", drop_out, 1);
        check("dropclr_head", result_out, 202);

        // Asynchronous reset mid-operation empties the FIFO immediately.
        rst_n = 1'b0;
        #1;
        check("async_count", count_out, 0);
        check("async_valid", valid_out, 0);
        check("async_ovf", overflow_out, 0);
        check("async_afull", afull_out, 0);
        rst_n = 1'b1;
        $display("txn async_reset");
        tick();

        // Push into empty with ready high: the pop request is ignored.
        valid_in = 1'b1; ready_in = 1'b1; result_in = 32'h77; status_in = 4'h4;
        tick();
        valid_in = 1'b0;
        $display("txn push_empty_ready result=77 count=%0d", count_out);
        check("ep_count", count_out, 1);
        check("ep_head", result_out, 32'h77);
        tick();
        ready_in = 1'b0;
        check("ep_drained", count_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
